// File: rtl/bsg_clkgate_ctrl_pkg.sv
// Shared types and helpers for the clock-gate idle-detect sequencer.
// Imported by the top controller.
package bsg_clkgate_ctrl_pkg;

  typedef enum logic [1:0] {
    eRun,
    eGated,
    eWake
  } bsg_clkgate_state_e;

  // Counter width that stays at least one bit for tiny parameters.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_clkgate_ctrl_sat_ctr.sv
// Saturating event counter; sticks at all-ones once reached.
// Asynchronous active-high reset.
module bsg_clkgate_ctrl_sat_ctr #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               incr_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r;
  logic               at_max;

  assign at_max  = &count_r;
  assign count_o = count_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (incr_i && !at_max) begin
      count_r <= count_r + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_clkgate_ctrl.sv
// Idle-detect sequencer driving one integrated clock-gate cell.
// Gates after a quiet streak, wakes on demand, then waits for settle.
module bsg_clkgate_ctrl
  import bsg_clkgate_ctrl_pkg::*;
#(
  parameter int num_req_p     = 4,
  parameter int idle_cycles_p = 16,
  parameter int wake_cycles_p = 2,
  parameter int stat_width_p  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [num_req_p-1:0]    req_i,
  input  logic                    busy_i,
  input  logic                    force_on_i,
  output logic                    en_o,
  output logic                    bypass_o,
  output logic                    ready_o,
  output logic [stat_width_p-1:0] gate_events_o
);

  localparam int IdleW = safe_clog2(idle_cycles_p);
  localparam int WakeW = safe_clog2(wake_cycles_p);

  localparam logic [IdleW-1:0] IdleLast =
    IdleW'(idle_cycles_p - 1);
  localparam logic [WakeW-1:0] WakeLast =
    WakeW'(wake_cycles_p - 1);

  bsg_clkgate_state_e state_r, state_n;

  logic [IdleW-1:0] idle_cnt_r, idle_cnt_n;
  logic [WakeW-1:0] wake_cnt_r, wake_cnt_n;

  logic en_r, en_n;
  logic ready_r, ready_n;
  logic bypass_r;
  logic gate_evt;
  logic active;

  assign active = (|req_i) | busy_i | force_on_i;

  always_comb begin
    state_n    = state_r;
    idle_cnt_n = idle_cnt_r;
    wake_cnt_n = wake_cnt_r;
    en_n       = en_r;
    ready_n    = ready_r;
    gate_evt   = 1'b0;
    unique case (state_r)
      eRun: begin
        en_n    = 1'b1;
        ready_n = 1'b1;
        if (active) begin
          idle_cnt_n = '0;
        end else if (idle_cnt_r == IdleLast) begin
          state_n    = eGated;
          en_n       = 1'b0;
          ready_n    = 1'b0;
          idle_cnt_n = '0;
          gate_evt   = 1'b1;
        end else begin
          idle_cnt_n = idle_cnt_r + 1'b1;
        end
      end
      eGated: begin
        en_n    = 1'b0;
        ready_n = 1'b0;
        if (active) begin
          state_n    = eWake;
          en_n       = 1'b1;
          wake_cnt_n = '0;
        end
      end
      eWake: begin
        // activity is irrelevant here; a wake always completes
        en_n    = 1'b1;
        ready_n = 1'b0;
        if (wake_cnt_r == WakeLast) begin
          state_n    = eRun;
          ready_n    = 1'b1;
          idle_cnt_n = '0;
        end else begin
          wake_cnt_n = wake_cnt_r + 1'b1;
        end
      end
      default: begin
        state_n    = eRun;
        en_n       = 1'b1;
        ready_n    = 1'b1;
        idle_cnt_n = '0;
        wake_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= eRun;
      idle_cnt_r <= '0;
      wake_cnt_r <= '0;
      en_r       <= 1'b1;
      ready_r    <= 1'b1;
      bypass_r   <= 1'b0;
    end else begin
      state_r    <= state_n;
      idle_cnt_r <= idle_cnt_n;
      wake_cnt_r <= wake_cnt_n;
      en_r       <= en_n;
      ready_r    <= ready_n;
      bypass_r   <= force_on_i;
    end
  end

  bsg_clkgate_ctrl_sat_ctr #(
    .width_p (stat_width_p)
  ) u_stat (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .incr_i  (gate_evt),
    .count_o (gate_events_o)
  );

  assign en_o     = en_r;
  assign ready_o  = ready_r;
  assign bypass_o = bypass_r;

endmodule
